// File: rtl/loop_recorder.sv
// loop_recorder: stereo loop capture/playback stage feeding the volume stage.
// Define LOOP_OVERDUB_EN to add overdub (record_req while playing mixes live input into the loop).
module loop_recorder #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned SAMPLE_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    record_req,
  input  logic                    play_req,
  input  logic                    stop_req,
  input  logic                    audio_in_available,
  input  logic [SAMPLE_WIDTH-1:0] left_channel_audio_in,
  input  logic [SAMPLE_WIDTH-1:0] right_channel_audio_in,
  output logic                    read_audio_in,
  output logic [SAMPLE_WIDTH-1:0] left_channel_audio_out,
  output logic [SAMPLE_WIDTH-1:0] right_channel_audio_out,
  output logic                    sample_valid,
  output logic [1:0]              state,
  output logic [ADDR_WIDTH:0]     loop_length
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RECORD  = 2'b01,
    ST_PLAY    = 2'b10,
    ST_OVERDUB = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    SRC_LIVE = 2'd0,
    SRC_LOOP = 2'd1,
    SRC_MIX  = 2'd2
  } src_e;

  localparam int unsigned           DEPTH    = 1 << ADDR_WIDTH;
  localparam int unsigned           WORD_W   = 2 * SAMPLE_WIDTH;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   LEN_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  src_e                  src_q, src_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [WORD_W-1:0]     live_q, live_d;
  logic                  valid_q, valid_d;

  logic                  tick;
  logic                  rd_last;
  logic                  rec_full;
  logic                  len_after_nz;
  logic [WORD_W-1:0]     live_in;

  logic [WORD_W-1:0]     mem [DEPTH];
  logic [WORD_W-1:0]     mem_rd_q;
  logic [WORD_W-1:0]     rd_word;
  logic [WORD_W-1:0]     out_word;
  logic                  mem_we;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [WORD_W-1:0]     mem_wd;

`ifdef LOOP_OVERDUB_EN
  logic                  wb_pending_q, wb_pending_d;
  logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
  logic                  fwd_q, fwd_d;
  logic [WORD_W-1:0]     fwd_data_q;
  logic [WORD_W-1:0]     mix_word;

  function automatic logic [SAMPLE_WIDTH-1:0] sat_add(
    input logic [SAMPLE_WIDTH-1:0] a,
    input logic [SAMPLE_WIDTH-1:0] b
  );
    logic [SAMPLE_WIDTH:0] s;
    s = {a[SAMPLE_WIDTH-1], a} + {b[SAMPLE_WIDTH-1], b};
    if (s[SAMPLE_WIDTH] != s[SAMPLE_WIDTH-1])
      return s[SAMPLE_WIDTH] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}}
                             : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    return s[SAMPLE_WIDTH-1:0];
  endfunction
`endif

  assign tick         = audio_in_available;
  assign live_in      = {left_channel_audio_in, right_channel_audio_in};
  assign rd_last      = ({1'b0, rd_addr_q} == (len_q - LEN_ONE));
  assign rec_full     = (state_q == ST_RECORD) && tick && (len_q == LEN_LAST);
  assign len_after_nz = tick || (len_q != '0);

  // State register and datapath flops; memory contents are deliberately not reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      src_q        <= SRC_LIVE;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      len_q        <= '0;
      live_q       <= '0;
      valid_q      <= 1'b0;
`ifdef LOOP_OVERDUB_EN
      wb_pending_q <= 1'b0;
      wb_addr_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      len_q        <= len_d;
      live_q       <= live_d;
      valid_q      <= valid_d;
`ifdef LOOP_OVERDUB_EN
      wb_pending_q <= wb_pending_d;
      wb_addr_q    <= wb_addr_d;
`endif
    end
  end

  // Next state: stop > record > play; a filling RECORD tick also moves to PLAY.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (stop_req)                       state_d = ST_IDLE;
        else if (record_req)                state_d = ST_RECORD;
        else if (play_req && len_q != '0)   state_d = ST_PLAY;
      end
      ST_RECORD: begin
        if (stop_req)                       state_d = ST_IDLE;
        else if (record_req)                state_d = ST_RECORD;
        else if (rec_full || (play_req && len_after_nz))
                                            state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (stop_req)                       state_d = ST_IDLE;
`ifdef LOOP_OVERDUB_EN
        else if (record_req)                state_d = ST_OVERDUB;
`else
        else if (record_req)                state_d = ST_RECORD;
`endif
      end
`ifdef LOOP_OVERDUB_EN
      ST_OVERDUB: begin
        if (stop_req)                       state_d = ST_IDLE;
        else if (play_req)                  state_d = ST_PLAY;
      end
`endif
      default:                              state_d = ST_IDLE;
    endcase
  end

  // Tick handling uses the pre-transition state; request side effects override afterwards.
  always_comb begin
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    len_d     = len_q;
    src_d     = src_q;
    live_d    = live_q;
    valid_d   = tick;
    mem_we    = 1'b0;
    mem_wa    = wr_addr_q;
    mem_wd    = live_in;
    rd_en     = 1'b0;
`ifdef LOOP_OVERDUB_EN
    wb_pending_d = 1'b0;
    wb_addr_d    = wb_addr_q;
`endif
    if (tick) begin
      live_d = live_in;
      unique case (state_q)
        ST_RECORD: begin
          mem_we    = 1'b1;
          wr_addr_d = wr_addr_q + ADDR_ONE;
          len_d     = len_q + LEN_ONE;
          src_d     = SRC_LIVE;
        end
        ST_PLAY: begin
          rd_en     = 1'b1;
          rd_addr_d = rd_last ? '0 : rd_addr_q + ADDR_ONE;
          src_d     = SRC_LOOP;
        end
`ifdef LOOP_OVERDUB_EN
        ST_OVERDUB: begin
          rd_en        = 1'b1;
          rd_addr_d    = rd_last ? '0 : rd_addr_q + ADDR_ONE;
          src_d        = SRC_MIX;
          wb_pending_d = 1'b1;
          wb_addr_d    = rd_addr_q;
        end
`endif
        default: src_d = SRC_LIVE;
      endcase
    end
    if (state_d == ST_RECORD && record_req) begin
      wr_addr_d = '0;
      len_d     = '0;
    end
    if (state_d == ST_PLAY && state_q != ST_PLAY && state_q != ST_OVERDUB)
      rd_addr_d = '0;
`ifdef LOOP_OVERDUB_EN
    if (wb_pending_q) begin
      mem_we = 1'b1;
      mem_wa = wb_addr_q;
      mem_wd = mix_word;
    end
    // Only a length-1 loop can read the address being written back this same cycle.
    fwd_d = rd_en && wb_pending_q && (wb_addr_q == rd_addr_q);
`endif
  end

  always_ff @(posedge clock) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
    if (rd_en) begin
      mem_rd_q <= mem[rd_addr_q];
`ifdef LOOP_OVERDUB_EN
      fwd_q      <= fwd_d;
      fwd_data_q <= mix_word;
`endif
    end
  end

`ifdef LOOP_OVERDUB_EN
  assign rd_word = fwd_q ? fwd_data_q : mem_rd_q;

  always_comb begin
    mix_word = {sat_add(rd_word[WORD_W-1:SAMPLE_WIDTH], live_q[WORD_W-1:SAMPLE_WIDTH]),
                sat_add(rd_word[SAMPLE_WIDTH-1:0],      live_q[SAMPLE_WIDTH-1:0])};
  end
`else
  assign rd_word = mem_rd_q;
`endif

  // Output source is latched per tick, so outputs hold across mode changes between ticks.
  always_comb begin
    out_word = live_q;
    case (src_q)
      SRC_LOOP: out_word = rd_word;
`ifdef LOOP_OVERDUB_EN
      SRC_MIX:  out_word = mix_word;
`endif
      default:  out_word = live_q;
    endcase
  end

  assign read_audio_in           = audio_in_available;
  assign left_channel_audio_out  = out_word[WORD_W-1:SAMPLE_WIDTH];
  assign right_channel_audio_out = out_word[SAMPLE_WIDTH-1:0];
  assign sample_valid            = valid_q;
  assign state                   = state_q;
  assign loop_length             = len_q;

endmodule

// File: tb/tb_loop_recorder.sv
// Table-driven bench for loop_recorder with ADDR_WIDTH=3 (8-sample loop).
// The overdub section is selected by LOOP_OVERDUB_EN to match the DUT build.
module tb_loop_recorder;
  localparam int AW = 3;
  localparam int SW = 32;

  localparam logic [3:0] N   = 4'b0000;
  localparam logic [3:0] T   = 4'b0001;
  localparam logic [3:0] STP = 4'b0010;
  localparam logic [3:0] PLY = 4'b0100;
  localparam logic [3:0] REC = 4'b1000;

  logic          clock;
  logic          reset;
  logic          record_req, play_req, stop_req, audio_in_available;
  logic [SW-1:0] l_in, r_in, l_out, r_out;
  logic          read_audio_in, sample_valid;
  logic [1:0]    state;
  logic [AW:0]   loop_length;

  loop_recorder #(.ADDR_WIDTH(AW), .SAMPLE_WIDTH(SW)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .record_req             (record_req),
    .play_req               (play_req),
    .stop_req               (stop_req),
    .audio_in_available     (audio_in_available),
    .left_channel_audio_in  (l_in),
    .right_channel_audio_in (r_in),
    .read_audio_in          (read_audio_in),
    .left_channel_audio_out (l_out),
    .right_channel_audio_out(r_out),
    .sample_valid           (sample_valid),
    .state                  (state),
    .loop_length            (loop_length)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] li;
    logic [31:0] ri;
    logic        ev;
    logic [31:0] el;
    logic [31:0] er;
    logic [1:0]  est;
    logic [3:0]  elen;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(input logic [3:0] req, input logic [31:0] li, input logic [31:0] ri,
                              input logic ev, input logic [31:0] el, input logic [31:0] er,
                              input logic [1:0] est, input logic [3:0] elen);
    vec_t v;
    v.req = req; v.li = li; v.ri = ri; v.ev = ev;
    v.el = el; v.er = er; v.est = est; v.elen = elen;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] req, input logic [31:0] li, input logic [31:0] ri);
    {record_req, play_req, stop_req, audio_in_available} = req;
    l_in = li;
    r_in = ri;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ev, input logic [31:0] el,
                         input logic [31:0] er, input logic [1:0] est, input logic [3:0] elen);
    chk({tag, " sample_valid"}, 32'(sample_valid), 32'(ev));
    chk({tag, " left_out"},     l_out,             el);
    chk({tag, " right_out"},    r_out,             er);
    chk({tag, " state"},        32'(state),        32'(est));
    chk({tag, " loop_length"},  32'(loop_length),  32'(elen));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    {record_req, play_req, stop_req, audio_in_available} = N;
    l_in = '0;
    r_in = '0;

    // Live pass-through in IDLE, play ignored with empty loop, 3-sample loop replay.
    add(T,   32'h10, 32'hFFFF_FFF0, 1'b1, 32'h10, 32'hFFFF_FFF0, 2'd0, 4'd0);
    add(PLY, 32'h0,  32'h0,         1'b0, 32'h10, 32'hFFFF_FFF0, 2'd0, 4'd0);
    add(REC, 32'h0,  32'h0,         1'b0, 32'h10, 32'hFFFF_FFF0, 2'd1, 4'd0);
    add(T,   32'h1,  32'h101,       1'b1, 32'h1,  32'h101,       2'd1, 4'd1);
    add(T,   32'h2,  32'h102,       1'b1, 32'h2,  32'h102,       2'd1, 4'd2);
    add(T,   32'h3,  32'h103,       1'b1, 32'h3,  32'h103,       2'd1, 4'd3);
    add(PLY, 32'h0,  32'h0,         1'b0, 32'h3,  32'h103,       2'd2, 4'd3);
    add(T,   32'hAA, 32'hBB,        1'b1, 32'h1,  32'h101,       2'd2, 4'd3);
    add(T,   32'hAA, 32'hBB,        1'b1, 32'h2,  32'h102,       2'd2, 4'd3);
    add(N,   32'hAA, 32'hBB,        1'b0, 32'h2,  32'h102,       2'd2, 4'd3);
    add(T,   32'hAA, 32'hBB,        1'b1, 32'h3,  32'h103,       2'd2, 4'd3);
    add(T,   32'hAA, 32'hBB,        1'b1, 32'h1,  32'h101,       2'd2, 4'd3);
    add(T,   32'hAA, 32'hBB,        1'b1, 32'h2,  32'h102,       2'd2, 4'd3);
    add(T,   32'hAA, 32'hBB,        1'b1, 32'h3,  32'h103,       2'd2, 4'd3);
    add(T,   32'hAA, 32'hBB,        1'b1, 32'h1,  32'h101,       2'd2, 4'd3);
    add(STP, 32'h0,  32'h0,         1'b0, 32'h1,  32'h101,       2'd0, 4'd3);
    add(T,   32'h77, 32'h88,        1'b1, 32'h77, 32'h88,        2'd0, 4'd3);
    // Full-depth recording auto-switches to PLAY on the 8th write.
    add(REC, 32'h0,  32'h0,         1'b0, 32'h77, 32'h88,        2'd1, 4'd0);
    for (int i = 1; i <= 8; i++)
      add(T, 32'(32'h10 + i), 32'(32'hF000_0000 + i), 1'b1, 32'(32'h10 + i),
          32'(32'hF000_0000 + i), (i == 8) ? 2'd2 : 2'd1, 4'(i));
    add(T,   32'h0,  32'h0,         1'b1, 32'h11, 32'hF000_0001, 2'd2, 4'd8);
    add(T,   32'h0,  32'h0,         1'b1, 32'h12, 32'hF000_0002, 2'd2, 4'd8);
    add(STP | REC | T, 32'h0, 32'h0, 1'b1, 32'h13, 32'hF000_0003, 2'd0, 4'd8);
    add(PLY, 32'h0,  32'h0,         1'b0, 32'h13, 32'hF000_0003, 2'd2, 4'd8);
    add(T,   32'h0,  32'h0,         1'b1, 32'h11, 32'hF000_0001, 2'd2, 4'd8);
`ifdef LOOP_OVERDUB_EN
    // Saturating overdub on a 2-sample loop, then a 1-sample loop needing forwarding.
    add(STP, 32'h0,  32'h0,         1'b0, 32'h11, 32'hF000_0001, 2'd0, 4'd8);
    add(REC, 32'h0,  32'h0,         1'b0, 32'h11, 32'hF000_0001, 2'd1, 4'd0);
    add(T,   32'h7FFF_FFF0, 32'h8000_0010, 1'b1, 32'h7FFF_FFF0, 32'h8000_0010, 2'd1, 4'd1);
    add(T,   32'h5,  32'h6,         1'b1, 32'h5,  32'h6,         2'd1, 4'd2);
    add(PLY, 32'h0,  32'h0,         1'b0, 32'h5,  32'h6,         2'd2, 4'd2);
    add(REC, 32'h0,  32'h0,         1'b0, 32'h5,  32'h6,         2'd3, 4'd2);
    add(T,   32'h100, 32'hFFFF_FF00, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd3, 4'd2);
    add(T,   32'h1,  32'h1,         1'b1, 32'h6,  32'h7,         2'd3, 4'd2);
    add(PLY, 32'h0,  32'h0,         1'b0, 32'h6,  32'h7,         2'd2, 4'd2);
    add(T,   32'h0,  32'h0,         1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd2, 4'd2);
    add(T,   32'h0,  32'h0,         1'b1, 32'h6,  32'h7,         2'd2, 4'd2);
    add(STP, 32'h0,  32'h0,         1'b0, 32'h6,  32'h7,         2'd0, 4'd2);
    add(REC, 32'h0,  32'h0,         1'b0, 32'h6,  32'h7,         2'd1, 4'd0);
    add(T,   32'hA,  32'h14,        1'b1, 32'hA,  32'h14,        2'd1, 4'd1);
    add(PLY, 32'h0,  32'h0,         1'b0, 32'hA,  32'h14,        2'd2, 4'd1);
    add(REC, 32'h0,  32'h0,         1'b0, 32'hA,  32'h14,        2'd3, 4'd1);
    add(T,   32'h1,  32'h1,         1'b1, 32'hB,  32'h15,        2'd3, 4'd1);
    add(T,   32'h1,  32'h1,         1'b1, 32'hC,  32'h16,        2'd3, 4'd1);
    add(T,   32'h1,  32'h1,         1'b1, 32'hD,  32'h17,        2'd3, 4'd1);
    add(STP, 32'h0,  32'h0,         1'b0, 32'hD,  32'h17,        2'd0, 4'd1);
`else
    // Without overdub, record_req while playing restarts a fresh recording.
    add(REC, 32'h0,  32'h0,         1'b0, 32'h11, 32'hF000_0001, 2'd1, 4'd0);
    add(T,   32'h42, 32'h43,        1'b1, 32'h42, 32'h43,        2'd1, 4'd1);
    add(STP, 32'h0,  32'h0,         1'b0, 32'h42, 32'h43,        2'd0, 4'd1);
    add(PLY, 32'h0,  32'h0,         1'b0, 32'h42, 32'h43,        2'd2, 4'd1);
    add(T,   32'h99, 32'h99,        1'b1, 32'h42, 32'h43,        2'd2, 4'd1);
    add(T,   32'h98, 32'h98,        1'b1, 32'h42, 32'h43,        2'd2, 4'd1);
    add(STP, 32'h0,  32'h0,         1'b0, 32'h42, 32'h43,        2'd0, 4'd1);
`endif

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk_all("reset", 1'b0, 32'h0, 32'h0, 2'd0, 4'd0);
    chk("reset read_audio_in", 32'(read_audio_in), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      {record_req, play_req, stop_req, audio_in_available} = vecs[i].req;
      l_in = vecs[i].li;
      r_in = vecs[i].ri;
      #1;
      chk($sformatf("v%0d read_audio_in", i), 32'(read_audio_in), 32'(vecs[i].req[0]));
      @(posedge clock);
      #1;
      chk_all($sformatf("v%0d", i), vecs[i].ev, vecs[i].el, vecs[i].er, vecs[i].est, vecs[i].elen);
    end

    // Asynchronous reset in the middle of a recording.
    cyc(STP, 32'h0, 32'h0);
    cyc(REC, 32'h0, 32'h0);
    for (int i = 1; i <= 3; i++)
      cyc(T, 32'(i), 32'(i + 100));
    chk_all("pre_reset", 1'b1, 32'h3, 32'd103, 2'd1, 4'd3);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 1'b0, 32'h0, 32'h0, 2'd0, 4'd0);
    cyc(N, 32'h0, 32'h0);
    reset = 1'b0;
    cyc(N, 32'h0, 32'h0);
    chk_all("post_reset", 1'b0, 32'h0, 32'h0, 2'd0, 4'd0);
    cyc(PLY, 32'h0, 32'h0);
    chk_all("post_reset_play", 1'b0, 32'h0, 32'h0, 2'd0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/loop_recorder.md
# loop_recorder

Stereo loop capture/playback stage sitting directly upstream of the volume stage. It pulls stereo samples from the audio codec input FIFO and records them into on-chip memory. It replays the recorded span endlessly, presenting one stereo sample per codec sample tick to the volume stage. While not replaying, it passes the live input through so the player hears itself.

## Interface
- ADDR_WIDTH, 12, log2 of loop depth in stereo samples (DEPTH = 2^ADDR_WIDTH)
- SAMPLE_WIDTH, 32, width of each channel sample, two's complement
- clock  in  1  single system clock; all logic on posedge
- reset  in  1  asynchronous, active-high; clears all state
- record_req  in  1  single-cycle pulse: start fresh recording
- play_req  in  1  single-cycle pulse: start loop playback
- stop_req  in  1  single-cycle pulse: return to idle
- audio_in_available  in  1  codec input FIFO holds a sample (the sample tick)
- left_channel_audio_in / right_channel_audio_in  in  SAMPLE_WIDTH  codec sample
- read_audio_in  out  1  combinational acknowledge = audio_in_available, in every state
- left_channel_audio_out / right_channel_audio_out  out  SAMPLE_WIDTH  registered sample to volume stage
- sample_valid  out  1  one-cycle pulse, outputs updated this cycle
- state  out  2  00 IDLE, 01 RECORD, 10 PLAY, 11 OVERDUB
- loop_length  out  ADDR_WIDTH+1  recorded samples, 0..DEPTH

## Operation
- Tick = cycle with audio_in_available=1; input consumed that cycle in all states. Ticks may be back-to-back.
- Request priority when several pulse together: stop > record > play. A request and a tick in the same cycle: the tick is handled per the current (pre-transition) state; the new state applies from the next cycle.
- IDLE: tick -> output = live input. record_req -> RECORD, wr_addr=0, loop_length=0. play_req with loop_length≠0 -> PLAY, rd_addr=0; ignored when loop_length=0.
- RECORD: tick -> write {L,R} to mem[wr_addr], wr_addr++, loop_length++, output = live input. The write that makes loop_length=DEPTH transitions to PLAY, rd_addr=0. stop_req -> IDLE (length kept). play_req -> PLAY if loop_length≠0, else ignored. record_req restarts at 0.
- PLAY: tick -> read mem[rd_addr]; output = that word. rd_addr wraps to 0 after rd_addr = loop_length-1. stop_req -> IDLE. record_req -> see Configuration.
- OVERDUB: like PLAY, but each tick’s output is the saturating per-channel sum of the loop word and the live input, also written back to the same address. stop_req -> IDLE; play_req -> PLAY (keeps rd_addr).
- Arithmetic: signed SAMPLE_WIDTH+1 add, clamp to 0x7FFFFFFF / 0x80000000 (32-bit case).
- Memory: synchronous read, one read + one write port, contents not cleared by reset.

## Timing
- Reset values: state=IDLE, loop_length=0, wr_addr=rd_addr=0, outputs 0, sample_valid=0.
- Every mode: sample_valid and new outputs exactly one cycle after the tick; outputs hold between pulses.
- OVERDUB write-back occurs in tick+1 at the address read in tick; next tick reads rd_addr+1 (wrapped), so no hazard unless loop_length=1, where write-back data must be forwarded to a same-address read.
- Reset mid-operation: immediate return to reset values; pending write-back dropped.

## Configuration
- LOOP_OVERDUB_EN defined: record_req in PLAY -> OVERDUB, rd_addr kept.
- Not defined: state 11 unreachable, no adder/write-back logic; record_req in PLAY -> RECORD, fresh from address 0.

## Test plan
- ADDR_WIDTH=3. Reset mid-RECORD after 3 ticks -> state=00, loop_length=0, outputs 0, sample_valid=0.
- IDLE, tick with L=0x00000010,R=0xFFFFFFF0 -> next cycle sample_valid=1, outputs equal inputs; play_req with length 0 ignored.
- record_req, 3 ticks (L=1,2,3), play_req, 7 ticks -> outputs L=1,2,3,1,2,3,1; loop_length=3.
- record_req, 8 ticks -> auto PLAY after 8th write, loop_length=8; 9th tick outputs first recorded sample.
- Same cycle stop_req+record_req+tick in PLAY -> tick output from loop, state=IDLE next cycle.
- LOOP_OVERDUB_EN: loop L=0x7FFFFFF0, overdub input 0x100 -> output and stored 0x7FFFFFFF; next lap plays 0x7FFFFFFF.
